// File: rtl/maquina_de_troco_pkg.sv
// Shared constants and state encoding for the change dispenser.
package maquina_de_troco_pkg;

    localparam int W_MOEDA = 5;
    localparam int W_VALOR = 6;
    localparam int W_ESTOQUE = 4;

    localparam logic [W_MOEDA-1:0] MOEDA20 = 5'd20;
    localparam logic [W_MOEDA-1:0] MOEDA10 = 5'd10;
    localparam logic [W_MOEDA-1:0] MOEDA5  = 5'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        OFFER  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } estado_t;

endpackage

// File: rtl/maquina_de_troco_estoque.sv
// Per-denomination coin stock: reloadable down-counter with empty flag.
module estoque_moeda
    import maquina_de_troco_pkg::*;
#(
    parameter logic [W_ESTOQUE-1:0] INICIAL = 4'd8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic vazio
);

    logic [W_ESTOQUE-1:0] cont;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont <= INICIAL;
        end else if (load) begin
            cont <= INICIAL;
        end else if (dec && cont != '0) begin
            cont <= cont - 1'b1;
        end
    end

    assign vazio = (cont == '0);

endmodule

// File: rtl/maquina_de_troco.sv
// Change dispenser: pays an amount greedily in 20/10/5 coins over a
// valid/ack handshake, tracking coin stock and reporting unpaid change.
module maquina_de_troco
    import maquina_de_troco_pkg::*;
#(
    parameter int unsigned ESTOQUE20 = 8,
    parameter int unsigned ESTOQUE10 = 8,
    parameter int unsigned ESTOQUE5  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W_VALOR-1:0] valor,
    input  logic               recarga,
    input  logic               ack,
    output logic [W_MOEDA-1:0] moeda,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               erro,
    output logic [W_VALOR-1:0] falta
);

    localparam logic [W_ESTOQUE-1:0] INI20 = ESTOQUE20[W_ESTOQUE-1:0];
    localparam logic [W_ESTOQUE-1:0] INI10 = ESTOQUE10[W_ESTOQUE-1:0];
    localparam logic [W_ESTOQUE-1:0] INI5  = ESTOQUE5[W_ESTOQUE-1:0];

    estado_t estado;
    logic [W_VALOR-1:0] restante;

    logic vazio20, vazio10, vazio5;
    logic dec20, dec10, dec5;
    logic recarregar;
    logic pega;

    logic c20, c10, c5;
    logic cabe;
    logic [W_MOEDA-1:0] escolha;

    // Stock changes only on an accepted coin or an idle reload.
    assign pega       = (estado == OFFER) && ack;
    assign dec20      = pega && (moeda == MOEDA20);
    assign dec10      = pega && (moeda == MOEDA10);
    assign dec5       = pega && (moeda == MOEDA5);
    assign recarregar = (estado == IDLE) && !start && recarga;

    estoque_moeda #(.INICIAL(INI20)) u_est20 (
        .clk   (clk),
        .reset (reset),
        .load  (recarregar),
        .dec   (dec20),
        .vazio (vazio20)
    );

    estoque_moeda #(.INICIAL(INI10)) u_est10 (
        .clk   (clk),
        .reset (reset),
        .load  (recarregar),
        .dec   (dec10),
        .vazio (vazio10)
    );

    estoque_moeda #(.INICIAL(INI5)) u_est5 (
        .clk   (clk),
        .reset (reset),
        .load  (recarregar),
        .dec   (dec5),
        .vazio (vazio5)
    );

    // Greedy pick, made mutually exclusive so the decoder is one-hot.
    assign c20  = (restante >= 6'd20) && !vazio20;
    assign c10  = !c20 && (restante >= 6'd10) && !vazio10;
    assign c5   = !c20 && !c10 && (restante >= 6'd5) && !vazio5;
    assign cabe = c20 || c10 || c5;

    always_comb begin
        escolha = '0;
        unique case (1'b1)
            c20:     escolha = MOEDA20;
            c10:     escolha = MOEDA10;
            c5:      escolha = MOEDA5;
            default: escolha = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= IDLE;
            restante <= '0;
            moeda    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            erro     <= 1'b0;
            falta    <= '0;
        end else begin
            unique case (estado)
                IDLE: begin
                    if (start) begin
                        restante <= valor;
                        falta    <= '0;
                        busy     <= 1'b1;
                        estado   <= SELECT;
                    end
                end
                SELECT: begin
                    if (restante == '0) begin
                        done   <= 1'b1;
                        estado <= DONE;
                    end else if (cabe) begin
                        moeda  <= escolha;
                        valid  <= 1'b1;
                        estado <= OFFER;
                    end else begin
                        falta  <= restante;
                        erro   <= 1'b1;
                        estado <= FAULT;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        restante <= restante - {1'b0, moeda};
                        moeda    <= '0;
                        valid    <= 1'b0;
                        estado   <= GAP;
                    end
                end
                GAP: begin
                    estado <= SELECT;
                end
                DONE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    estado <= IDLE;
                end
                FAULT: begin
                    erro   <= 1'b0;
                    busy   <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule
